cam_match_array: RTL
====================

// Module: cam_match_array
// PURPOSE
//   Parametrised binary/ternary CAM core: DEPTH stored words of WIDTH bits, each with a valid bit.
//   A search compares a key against all valid words in parallel. Each entry's per-bit compares are
//   AND-reduced into a match line, and the match lines are priority-encoded to the lowest index.
//   Registered, 2-stage search pipeline. Generalises the 4x4 CAM match/AND path; sits between
//   the lookup controller and the result consumer.
// PARAMETERS
//   WIDTH  4  bits per stored word and per search key
//   DEPTH  4  number of entries (>=2); AW = $clog2(DEPTH) is a localparam, not a parameter
// PORTS
//   clk         in   1         rising-edge clock
//   rst         in   1         synchronous, active-high reset
//   wr_en       in   1         write entry wr_addr this cycle
//   wr_addr     in   AW        entry index; values >= DEPTH are ignored (no write)
//   wr_data     in   WIDTH     word to store
//   wr_valid    in   1         valid bit written with the word (0 = invalidate entry)
//   clr_all     in   1         invalidate all entries this cycle
//   srch_en     in   1         launch a search this cycle
//   srch_key    in   WIDTH     search key
//   srch_mask   in   WIDTH     1 = compare this bit, 0 = don't care
//   rslt_valid  out  1         result qualifier, exactly 2 cycles after srch_en
//   rslt_hit    out  1         at least one entry matched
//   rslt_addr   out  AW        lowest matching index (0 when no hit)
//   rslt_multi  out  1         two or more entries matched
//   rslt_match  out  DEPTH     raw match-line vector, bit i = entry i
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): all valid bits=0, pipeline flushed, every output=0.
//     Stored data is don't-care after reset. An in-flight search is discarded, so no rslt_valid follows.
//   - Match line i = valid[i] & AND over b of (~srch_mask[b] | (word[i][b] ~^ srch_key[b])).
//     srch_mask all-zero matches every valid entry. An invalid entry never matches.
//   - Stage 1, cycle N edge: register the match vector and a valid flag (= srch_en).
//   - Stage 2, cycle N+1 edge: register rslt_*. rslt_valid is high in cycle N+2 for exactly 1 cycle.
//   - Fully pipelined: a new search is accepted every cycle, with no backpressure.
//   - When rslt_valid=0, rslt_hit, rslt_multi, rslt_addr and rslt_match are held at 0.
//   - Write/search collision in the same cycle: the search sees contents from before the write.
//     The write takes effect at that edge.
//   - clr_all and wr_en in the same cycle: clr_all wins, all entries invalid,
//     and the write of wr_data is still performed.
//   - clr_all with srch_en in the same cycle: the search sees the pre-clear state.
//   - Priority: the lowest index wins. The encoder is purely combinational between the stage registers.
//   - No state machine: the state is the storage plus the 2-deep valid shift pipeline.
// TESTING
//   1 Reset: assert rst 2 cycles, then search key=4'hF mask=4'hF
//     -> rslt_valid at +2, hit=0, match=4'b0000.
//   2 Exact hit: write e0=4'h3, e2=4'hA (valid=1), search key=4'hA mask=4'hF
//     -> hit=1, addr=2, multi=0, match=4'b0100.
//   3 Ternary multi: e0=4'h3, e1=4'h7, search key=4'h3 mask=4'b0011
//     -> match=4'b0011, addr=0, multi=1.
//   4 Collision: e1=4'h5; in one cycle write e1=4'h6 and search key=4'h6 mask=4'hF
//     -> no hit. The same search 1 cycle later -> hit, addr=1.
//   5 Back-to-back: 3 consecutive searches (hit e2, miss, hit e0)
//     -> rslt_valid high 3 consecutive cycles with results in order.
//   6 Reset mid-flight: srch_en at cycle N, rst at N+1
//     -> no rslt_valid at N+2, all outputs 0. clr_all then search mask=0 -> hit=0.

Source files
------------

// File: rtl/cam_match_array.sv
// Binary/ternary CAM core: DEPTH valid-tagged words searched in parallel, with
// lowest-index priority encode and a two-stage registered search pipeline.
module cam_match_array #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    input  logic             clr_all,
    input  logic             srch_en,
    input  logic [WIDTH-1:0] srch_key,
    input  logic [WIDTH-1:0] srch_mask,
    output logic             rslt_valid,
    output logic             rslt_hit,
    output logic [AW-1:0]    rslt_addr,
    output logic             rslt_multi,
    output logic [DEPTH-1:0] rslt_match
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] match_line;

    logic             s1_valid_q, s1_valid_d;
    logic [DEPTH-1:0] s1_match_q, s1_match_d;

    logic             rslt_valid_q, rslt_valid_d;
    logic             rslt_hit_q, rslt_hit_d;
    logic [AW-1:0]    rslt_addr_q, rslt_addr_d;
    logic             rslt_multi_q, rslt_multi_d;
    logic [DEPTH-1:0] rslt_match_q, rslt_match_d;

    // clr_all overrides the valid bit of a same-cycle write, but the data still lands.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            data_d[wr_addr]  = wr_data;
            valid_d[wr_addr] = wr_valid;
        end
        if (clr_all) begin
            valid_d = '0;
        end
    end

    // Match lines use the registered contents, so a same-cycle write is not visible.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_line[i] = valid_q[i] & (&(~srch_mask | ~(data_q[i] ^ srch_key)));
        end
    end

    always_comb begin
        s1_valid_d = srch_en;
        s1_match_d = srch_en ? match_line : '0;
    end

    always_comb begin
        rslt_valid_d = s1_valid_q;
        rslt_hit_d   = 1'b0;
        rslt_addr_d  = '0;
        rslt_multi_d = 1'b0;
        rslt_match_d = '0;
        if (s1_valid_q) begin
            rslt_match_d = s1_match_q;
            rslt_hit_d   = |s1_match_q;
            rslt_multi_d = |(s1_match_q & (s1_match_q - DEPTH'(1)));
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (s1_match_q[i]) begin
                    rslt_addr_d = AW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_match_q   <= '0;
            rslt_valid_q <= 1'b0;
            rslt_hit_q   <= 1'b0;
            rslt_addr_q  <= '0;
            rslt_multi_q <= 1'b0;
            rslt_match_q <= '0;
        end else begin
            valid_q      <= valid_d;
            s1_valid_q   <= s1_valid_d;
            s1_match_q   <= s1_match_d;
            rslt_valid_q <= rslt_valid_d;
            rslt_hit_q   <= rslt_hit_d;
            rslt_addr_q  <= rslt_addr_d;
            rslt_multi_q <= rslt_multi_d;
            rslt_match_q <= rslt_match_d;
        end
    end

    assign rslt_valid = rslt_valid_q;
    assign rslt_hit   = rslt_hit_q;
    assign rslt_addr  = rslt_addr_q;
    assign rslt_multi = rslt_multi_q;
    assign rslt_match = rslt_match_q;

endmodule
